// File: rtl/sd_asset_loader.sv
// Copies WORD_COUNT consecutive 32-bit words from the SD card into BRAM addresses 0..WORD_COUNT-1.
// It issues one read at a time and writes each returned word to memory with a single-cycle mem_we pulse.
module sd_asset_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          ADDR_STEP  = 1,
    parameter int          WORD_COUNT = 1024,
    parameter int          MEM_AW     = 10,
    parameter logic [23:0] TIMEOUT    = 24'd5_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              sd_initialized,
    input  logic              sd_read_complete,
    input  logic [31:0]       sd_data,
    output logic [31:0]       sd_addr,
    output logic              sd_read_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [MEM_AW:0]   words_loaded
);

    localparam int              CW           = MEM_AW + 1;
    localparam logic [MEM_AW:0] LAST_INDEX   = CW'(WORD_COUNT - 1);
    localparam logic [31:0]     STEP32       = 32'(ADDR_STEP);
    localparam logic [23:0]     TIMEOUT_LAST = TIMEOUT - 24'd1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INIT,
        REQ,
        WRITE,
        RELEASE,
        FINISH,
        FAIL
    } state_t;

    state_t            state_q, state_d;
    logic [MEM_AW-1:0] index_q, index_d;
    logic [23:0]       timer_q, timer_d;
    logic [31:0]       sd_addr_q, sd_addr_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [MEM_AW:0]   words_q, words_d;

    function automatic logic [31:0] addr_for(input logic [MEM_AW-1:0] idx);
        return BASE_ADDR + 32'(idx) * STEP32;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            index_q     <= '0;
            timer_q     <= '0;
            sd_addr_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            timer_q     <= timer_d;
            sd_addr_q   <= sd_addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            words_q     <= words_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        timer_d     = timer_q;
        sd_addr_d   = sd_addr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        words_d     = words_q;

        case (state_q)
            IDLE, FINISH, FAIL: begin
                if (start) begin
                    state_d = WAIT_INIT;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    index_d = '0;
                    words_d = '0;
                    timer_d = '0;
                end
            end

            WAIT_INIT: begin
                if (sd_initialized) begin
                    state_d   = REQ;
                    sd_addr_d = addr_for(index_q);
                    timer_d   = '0;
                end
            end

            REQ: begin
                if (sd_read_complete) begin
                    mem_wdata_d = sd_data;
                    mem_addr_d  = index_q;
                    timer_d     = '0;
                    state_d     = WRITE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = FAIL;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                end else begin
                    timer_d = timer_q + 24'd1;
                end
            end

            WRITE: begin
                words_d = words_q + 1'b1;
                state_d = RELEASE;
            end

            // Wait for a level-type complete to drop so one word is never counted twice.
            RELEASE: begin
                if (!sd_read_complete) begin
                    timer_d = '0;
                    if ({1'b0, index_q} == LAST_INDEX) begin
                        state_d = FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        index_d   = index_q + 1'b1;
                        sd_addr_d = addr_for(index_q + 1'b1);
                        state_d   = REQ;
                    end
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = FAIL;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                end else begin
                    timer_d = timer_q + 24'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign sd_read_req  = (state_q == REQ);
    assign mem_we       = (state_q == WRITE);
    assign sd_addr      = sd_addr_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule
